conv_window_engine: RTL and testbench

Parametrised K-tap convolution engine for the realtime filter pipeline. It buffers a window of K pixels through a valid/ready stream and holds K signed coefficients in a writable bank. It then runs a one-tap-per-cycle multiply-accumulate in either correlation or convolution (flipped-kernel) order, and returns a normalised, clamped pixel through a valid/ready result port. It sits between the pixel-window fetcher and the frame writer, and replaces the fixed 9-tap hand-loaded controller.

---
 rtl/conv_window_engine.sv | 170 +++++++++++++++++
 tb/tb_conv_window_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_engine.sv
// K-tap convolution engine: buffers a K-pixel window, runs one MAC per cycle in
// correlation or flipped-kernel order, and returns a normalised, clamped pixel.
module conv_window_engine #(
    parameter int K        = 9,
    parameter int PIX_W    = 8,
    parameter int COEF_W   = 8,
    parameter int SHIFT_W  = 4,
    localparam int IDX_W   = $clog2(K),
    localparam int ACC_W   = PIX_W + COEF_W + $clog2(K) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               coef_we,
    input  logic [IDX_W-1:0]   coef_addr,
    input  logic [COEF_W-1:0]  coef_data,
    input  logic               flip,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic               res_valid,
    output logic [PIX_W-1:0]   res_data,
    input  logic               res_ready,
    output logic               busy
);

    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
    localparam logic [IDX_W:0]   K_EXT    = (IDX_W + 1)'(K);
    localparam logic signed [ACC_W-1:0] PIX_MAX = {{(ACC_W - PIX_W){1'b0}}, {PIX_W{1'b1}}};

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          widx_q, widx_d;
    logic [IDX_W-1:0]          t_q, t_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [PIX_W-1:0]          pix_q [K];
    logic [PIX_W-1:0]          pix_d [K];
    logic signed [COEF_W-1:0]  coef_q [K];
    logic signed [COEF_W-1:0]  coef_d [K];
    logic                      flip_l_q, flip_l_d;
    logic [SHIFT_W-1:0]        shift_l_q, shift_l_d;
    logic [PIX_W-1:0]          res_data_q, res_data_d;

    logic                      pix_accept;
    logic                      last_pix;
    logic                      last_tap;
    logic [IDX_W-1:0]          coef_idx;
    logic signed [PIX_W:0]     pix_ext;
    logic signed [PROD_W-1:0]  pix_wide;
    logic signed [PROD_W-1:0]  coef_wide;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_shift;
    logic [PIX_W-1:0]          res_clamped;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= LOAD;
            widx_q     <= '0;
            t_q        <= '0;
            acc_q      <= '0;
            flip_l_q   <= 1'b0;
            shift_l_q  <= '0;
            res_data_q <= '0;
            for (int i = 0; i < K; i++) begin
                pix_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            t_q        <= t_d;
            acc_q      <= acc_d;
            flip_l_q   <= flip_l_d;
            shift_l_q  <= shift_l_d;
            res_data_q <= res_data_d;
            pix_q      <= pix_d;
            coef_q     <= coef_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (pix_accept && last_pix) state_d = CALC;
            CALC:    if (last_tap) state_d = OUT;
            OUT:     if (res_ready) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        pix_ready = (state_q == LOAD);
        busy      = (state_q == CALC) || (state_q == OUT);
        res_valid = (state_q == OUT);
        res_data  = res_data_q;
    end

    // Tap datapath: the pixel is zero-extended so it multiplies as a positive signed value.
    always_comb begin
        pix_accept = pix_valid && (state_q == LOAD);
        last_pix   = (widx_q == LAST_IDX);
        last_tap   = (state_q == CALC) && (t_q == LAST_IDX);
        coef_idx   = flip_l_q ? (LAST_IDX - t_q) : t_q;
        pix_ext    = $signed({1'b0, pix_q[t_q]});
        pix_wide   = PROD_W'(pix_ext);
        coef_wide  = PROD_W'(coef_q[coef_idx]);
        prod       = pix_wide * coef_wide;
        acc_sum    = $signed(acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
        acc_shift  = acc_sum >>> shift_l_q;
        if (acc_shift[ACC_W-1]) begin
            res_clamped = '0;
        end else if (acc_shift > PIX_MAX) begin
            res_clamped = '1;
        end else begin
            res_clamped = acc_shift[PIX_W-1:0];
        end
    end

    always_comb begin
        widx_d     = widx_q;
        t_d        = t_q;
        acc_d      = acc_q;
        flip_l_d   = flip_l_q;
        shift_l_d  = shift_l_q;
        res_data_d = res_data_q;
        pix_d      = pix_q;
        coef_d     = coef_q;
        unique case (state_q)
            LOAD: begin
                if (pix_accept) begin
                    pix_d[widx_q] = pix_data;
                    if (last_pix) begin
                        widx_d    = '0;
                        t_d       = '0;
                        acc_d     = '0;
                        flip_l_d  = flip;
                        shift_l_d = shift;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
                // The bank is writable only while loading, so a window never sees a torn kernel.
                if (coef_we && ({1'b0, coef_addr} < K_EXT)) begin
                    coef_d[coef_addr] = coef_data;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                if (last_tap) begin
                    t_d        = '0;
                    res_data_d = res_clamped;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            OUT: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_conv_window_engine.sv
// Directed bench for conv_window_engine (K=9, 8-bit pixels and coefficients)
// with hand-computed expected results.
`timescale 1ns/1ps
module tb_conv_window_engine;

    logic       clk       = 1'b0;
    logic       resetn    = 1'b0;
    logic       coef_we   = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [7:0] coef_data = '0;
    logic       flip      = 1'b0;
    logic [3:0] shift     = '0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data  = '0;
    logic       res_ready = 1'b1;
    logic       pix_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;

    int         checkCount = 0;
    int         errorCount = 0;
    logic [7:0] win [9];
    logic [7:0] resValue;
    int         resEdges;
    time        resTime;
    time        firstTime;

    conv_window_engine #(
        .K(9),
        .PIX_W(8),
        .COEF_W(8),
        .SHIFT_W(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .flip(flip),
        .shift(shift),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_ready(pix_ready),
        .res_valid(res_valid),
        .res_data(res_data),
        .res_ready(res_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic writeCoef(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic setAllCoef(input logic [7:0] data);
        for (int i = 0; i < 9; i++) writeCoef(4'(i), data);
    endtask

    task automatic setIdentity();
        for (int i = 0; i < 9; i++) writeCoef(4'(i), (i == 4) ? 8'd1 : 8'd0);
    endtask

    task automatic pushPixel(input logic [7:0] value);
        int budget;
        budget    = 0;
        pix_valid = 1'b1;
        pix_data  = value;
        while (!pix_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) checkOutput("pixReadyTimeout", 0, 1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic flipVal, input logic [3:0] shiftVal);
        flip  = flipVal;
        shift = shiftVal;
        for (int i = 0; i < 9; i++) pushPixel(win[i]);
    endtask

    // resEdges is the index, counted from the final accept edge, of the first edge at which res_valid is seen high
    task automatic waitResult();
        bit got;
        got      = 1'b0;
        resEdges = 0;
        for (int b = 0; b < 100; b++) begin
            @(negedge clk);
            resEdges++;
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("resultTimeout", 0, 1);
        resValue = res_data;
        resTime  = $time;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstPixReady", int'(pix_ready), 1);
        checkOutput("rstResValid", int'(res_valid), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstResData", int'(res_data), 0);
        @(negedge clk);
        resetn = 1'b1;

        writeCoef(4'd4, 8'd1);
        for (int i = 0; i < 9; i++) win[i] = 8'(10 * (i + 1));
        applyStimulus(1'b0, 4'd0);
        checkOutput("calcBusy", int'(busy), 1);
        checkOutput("calcPixReady", int'(pix_ready), 0);
        waitResult();
        checkOutput("identCorr", int'(resValue), 50);
        checkOutput("identCorrLatency", resEdges, 10);
        applyStimulus(1'b1, 4'd0);
        waitResult();
        checkOutput("identConv", int'(resValue), 50);
        checkOutput("identConvLatency", resEdges, 10);

        setAllCoef(8'd1);
        for (int i = 0; i < 9; i++) win[i] = 8'd200;
        applyStimulus(1'b0, 4'd3);
        waitResult();
        firstTime = resTime;
        checkOutput("boxFirst", int'(resValue), 225);
        applyStimulus(1'b0, 4'd3);
        waitResult();
        checkOutput("boxSecond", int'(resValue), 225);
        checkOutput("boxPeriod", int'((resTime - firstTime) / 10), 19);

        for (int i = 0; i < 9; i++) win[i] = 8'd255;
        applyStimulus(1'b0, 4'd0);
        waitResult();
        checkOutput("clampHigh", int'(resValue), 255);
        setAllCoef(8'hFF);
        applyStimulus(1'b0, 4'd0);
        waitResult();
        checkOutput("clampLow", int'(resValue), 0);

        for (int i = 0; i < 9; i++) writeCoef(4'(i), 8'(i));
        win[0] = 8'd100;
        for (int i = 1; i < 9; i++) win[i] = 8'd1;
        applyStimulus(1'b0, 4'd2);
        waitResult();
        checkOutput("flipCorr", int'(resValue), 9);
        applyStimulus(1'b1, 4'd2);
        waitResult();
        checkOutput("flipConv", int'(resValue), 207);
        applyStimulus(1'b1, 4'd2);
        @(negedge clk);
        flip  = 1'b0;
        shift = 4'd0;
        waitResult();
        checkOutput("flipToggleConv", int'(resValue), 207);
        applyStimulus(1'b0, 4'd2);
        @(negedge clk);
        flip  = 1'b1;
        shift = 4'd7;
        waitResult();
        checkOutput("flipToggleCorr", int'(resValue), 9);

        setIdentity();
        for (int i = 0; i < 9; i++) win[i] = 8'(10 * (i + 1));
        res_ready = 1'b0;
        applyStimulus(1'b0, 4'd0);
        waitResult();
        checkOutput("bpValue", int'(resValue), 50);
        coef_we   = 1'b1;
        coef_addr = 4'd4;
        coef_data = 8'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            coef_we = 1'b0;
            checkOutput("bpResValid", int'(res_valid), 1);
            checkOutput("bpResData", int'(res_data), 50);
            checkOutput("bpPixReady", int'(pix_ready), 0);
            checkOutput("bpBusy", int'(busy), 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpRelease", int'(res_valid), 0);
        writeCoef(4'd12, 8'd5);
        applyStimulus(1'b0, 4'd0);
        waitResult();
        checkOutput("lockoutRerun", int'(resValue), 50);

        for (int i = 0; i < 4; i++) pushPixel(8'd50);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midLoadRstReady", int'(pix_ready), 1);
        checkOutput("midLoadRstBusy", int'(busy), 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 9; i++) win[i] = 8'd100;
        applyStimulus(1'b0, 4'd0);
        waitResult();
        checkOutput("midLoadRstValue", int'(resValue), 0);
        checkOutput("midLoadRstLatency", resEdges, 10);

        setIdentity();
        for (int i = 0; i < 9; i++) win[i] = 8'(10 * (i + 1));
        res_ready = 1'b0;
        applyStimulus(1'b0, 4'd0);
        waitResult();
        checkOutput("outRstBefore", int'(resValue), 50);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("outRstValid", int'(res_valid), 0);
        checkOutput("outRstData", int'(res_data), 0);
        checkOutput("outRstBusy", int'(busy), 0);
        checkOutput("outRstReady", int'(pix_ready), 1);
        @(negedge clk);
        resetn    = 1'b1;
        res_ready = 1'b1;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
